dds_phase_acc: RTL and testbench
================================

Name: dds_phase_acc

Overview:
Phase-accumulator front end of the DDS chain, placed directly upstream of the waveform-select/ROM stage. It generates the ROM address and enable each sclk cycle from a frequency tuning word and a phase offset. It also supports continuous or N-cycle burst operation, and can apply a new configuration either immediately or synchronised to a waveform wrap so the output has no phase glitch.

Parameters:
ACC_BIT, 32, phase accumulator width
ADDR_BIT, 12, ROM address width; must be <= ACC_BIT
CYC_BIT, 16, burst cycle counter width

Ports:
sclk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin generation (sampled in IDLE only)
stop  input  1  request stop at next wrap (sampled in RUN only)
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when valid&&ready
cfg_fword  input  ACC_BIT  frequency tuning word
cfg_poff  input  ADDR_BIT  phase offset added to address
cfg_ncyc  input  CYC_BIT  burst length in waveform periods; 0 = continuous
cfg_sync  input  1  1 = defer application to next wrap while running
addr  output  ADDR_BIT  ROM address (registered)
en  output  1  ROM enable (registered)
wrap  output  1  one-cycle pulse, accumulator overflowed on this step
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on return to IDLE

Behaviour:
- One clock, sclk. Reset is synchronous and active-high on rst.
- Reset values, applied at the next edge after rst=1, including mid-operation: acc=0, active fword/poff/ncyc=0, pending config cleared, addr=0, en=0, wrap=0, busy=0, done=0, cfg_ready=1, state IDLE.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - start=1: acc<=0, period counter<=0, go to RUN.
  - The first RUN-cycle output is addr=poff, en=1.
  - stop is ignored in IDLE. If start and stop are both high, start is taken.
- RUN and STOPPING, each cycle:
  - {carry,acc} <= acc + fword, modulo 2^ACC_BIT.
  - addr <= acc_next[ACC_BIT-1 -: ADDR_BIT] + poff, modulo 2^ADDR_BIT.
  - en <= 1.
  - wrap <= carry, aligned with the addr that follows the overflow.
- Period counter increments on every carry. When ncyc!=0 and the counter reaches ncyc on a carry, the FSM enters IDLE.
- RUN with stop=1 goes to STOPPING. STOPPING goes to IDLE on the next carry. If stop and carry occur in the same cycle, that carry ends the run.
- Whenever the active fword==0, no carry can occur. Stop, or ncyc termination, then goes to IDLE on the next cycle without waiting for a wrap.
- Entering IDLE:
  - The cycle after the terminating step: en=0, done=1 for exactly one cycle, busy=0.
  - addr holds its last value.
- Configuration handshake:
  - Transfer occurs on cfg_valid&&cfg_ready.
  - In IDLE, or when cfg_sync=0: the word becomes active at the next edge and affects the accumulation step after it. cfg_ready stays 1.
  - In RUN/STOPPING with cfg_sync=1: the word is held pending and cfg_ready=0. It is applied at the step whose carry=1, so the next step uses the new fword/poff. cfg_ready returns to 1 on the following cycle.
  - If the active fword==0, a pending config is applied at the next edge.
  - A new ncyc does not reset the period counter. If the counter is already >= the new ncyc, termination occurs on the next carry.
- Latency: acc to addr is 1 cycle. The downstream ROM adds 1 more.
- rst overrides start, stop and cfg transfers in the same cycle.

Decomposition:
- Package dds_pkg holds:
  - FSM state enum (IDLE/RUN/STOPPING).
  - Waveform select codes shared with the select stage (SIN=0, TIR=1, SAW=2, SQU=3).
  - Default width constants.
- One natural sub-module, dds_cfg_stage: active/pending config registers, the cfg_ready handshake and the sync-at-wrap apply logic. Its inputs are wrap, state and fword_zero.
- Accumulator, FSM and counter stay in the top module.

Test Plan:
All scenarios use ACC_BIT=16, ADDR_BIT=12.
- Reset then start: fword=0x1000, poff=0, ncyc=0, start -> addr sequence 0x000,0x100,...,0xF00,0x000; wrap=1 with addr=0x000 every 16 cycles; en=1 continuously.
- Burst: ncyc=2, start -> exactly 32 enabled cycles, then en=0 and a single done pulse; busy low afterwards.
- Synced retune: during RUN, offer fword=0x2000 with cfg_sync=1 at addr=0x500 -> cfg_ready=0 until wrap; after wrap the steps are 0x200; no step change before wrap.
- Immediate retune and offset: cfg_sync=0, poff=0x800 during RUN -> addr jumps by 0x800 one cycle after the handshake; cfg_ready never drops.
- Stop edge cases:
  - stop asserted in the same cycle as carry -> IDLE next cycle.
  - fword=0 then stop -> done after 1 cycle.
  - start+stop in IDLE -> runs.
- Mid-run rst at an arbitrary cycle -> next cycle all outputs at reset values and the pending config is discarded.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS chain.
// No logic; imported by the phase accumulator and the waveform-select stage.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } dds_state_e;

    typedef enum logic [1:0] {
        WAVE_SIN = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SAW = 2'd2,
        WAVE_SQU = 2'd3
    } wave_sel_e;

    localparam int ACC_BIT_DEF  = 32;
    localparam int ADDR_BIT_DEF = 12;
    localparam int CYC_BIT_DEF  = 16;

endpackage

// File: rtl/dds_cfg_stage.sv
// Active/pending configuration registers; a word lands one edge after transfer, or at the
// next wrap when synced while running. cfg_ready_o drops only while a synced word waits.
module dds_cfg_stage
    import dds_pkg::*;
#(
    parameter int ACC_BIT  = ACC_BIT_DEF,
    parameter int ADDR_BIT = ADDR_BIT_DEF,
    parameter int CYC_BIT  = CYC_BIT_DEF
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [ACC_BIT-1:0]  cfg_fword_i,
    input  logic [ADDR_BIT-1:0] cfg_poff_i,
    input  logic [CYC_BIT-1:0]  cfg_ncyc_i,
    input  logic                cfg_sync_i,
    input  dds_state_e          state_i,
    input  logic                wrap_i,
    input  logic                fword_zero_i,
    output logic [ACC_BIT-1:0]  fword_o,
    output logic [ADDR_BIT-1:0] poff_o,
    output logic [CYC_BIT-1:0]  ncyc_o
);

    logic [ACC_BIT-1:0]  fword_q, fword_d, pfword_q, pfword_d;
    logic [ADDR_BIT-1:0] poff_q, poff_d, ppoff_q, ppoff_d;
    logic [CYC_BIT-1:0]  ncyc_q, ncyc_d, pncyc_q, pncyc_d;
    logic                pend_q, pend_d;
    logic                running;
    logic                take;

    assign running     = (state_i != IDLE);
    assign take        = cfg_valid_i & ~pend_q;
    assign cfg_ready_o = ~pend_q;

    always_comb begin
        fword_d  = fword_q;
        poff_d   = poff_q;
        ncyc_d   = ncyc_q;
        pfword_d = pfword_q;
        ppoff_d  = ppoff_q;
        pncyc_d  = pncyc_q;
        pend_d   = pend_q;
        // A stalled accumulator (fword 0) never wraps, so a waiting word is released at once.
        if (pend_q && (wrap_i || fword_zero_i || !running)) begin
            fword_d = pfword_q;
            poff_d  = ppoff_q;
            ncyc_d  = pncyc_q;
            pend_d  = 1'b0;
        end
        if (take) begin
            if (running && cfg_sync_i) begin
                pfword_d = cfg_fword_i;
                ppoff_d  = cfg_poff_i;
                pncyc_d  = cfg_ncyc_i;
                pend_d   = 1'b1;
            end else begin
                fword_d = cfg_fword_i;
                poff_d  = cfg_poff_i;
                ncyc_d  = cfg_ncyc_i;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            fword_q  <= '0;
            poff_q   <= '0;
            ncyc_q   <= '0;
            pfword_q <= '0;
            ppoff_q  <= '0;
            pncyc_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            fword_q  <= fword_d;
            poff_q   <= poff_d;
            ncyc_q   <= ncyc_d;
            pfword_q <= pfword_d;
            ppoff_q  <= ppoff_d;
            pncyc_q  <= pncyc_d;
            pend_q   <= pend_d;
        end
    end

    assign fword_o = fword_q;
    assign poff_o  = poff_q;
    assign ncyc_o  = ncyc_q;

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: ROM address/enable one cycle after each accumulator step,
// continuous or N-period burst; no backpressure, the ROM consumes every enabled cycle.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_BIT  = ACC_BIT_DEF,
    parameter int ADDR_BIT = ADDR_BIT_DEF,
    parameter int CYC_BIT  = CYC_BIT_DEF
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ACC_BIT-1:0]  cfg_fword,
    input  logic [ADDR_BIT-1:0] cfg_poff,
    input  logic [CYC_BIT-1:0]  cfg_ncyc,
    input  logic                cfg_sync,
    output logic [ADDR_BIT-1:0] addr,
    output logic                en,
    output logic                wrap,
    output logic                busy,
    output logic                done
);

    dds_state_e          state_q, state_d;
    logic [ACC_BIT-1:0]  acc_q, acc_d;
    logic [CYC_BIT-1:0]  cnt_q, cnt_d;
    logic [ADDR_BIT-1:0] addr_q, addr_d;
    logic                en_q, en_d, wrap_q, wrap_d, done_q, done_d;

    logic [ACC_BIT-1:0]  act_fword;
    logic [ADDR_BIT-1:0] act_poff;
    logic [CYC_BIT-1:0]  act_ncyc;

    logic [ACC_BIT:0]    sum;
    logic                carry;
    logic [ACC_BIT-1:0]  acc_step;
    logic [ADDR_BIT-1:0] addr_step;
    logic                fword_zero;
    logic                burst;
    logic                cnt_hit;
    logic                step_carry;
    logic                terminate;

    assign sum        = {1'b0, acc_q} + {1'b0, act_fword};
    assign carry      = sum[ACC_BIT];
    assign acc_step   = sum[ACC_BIT-1:0];
    assign addr_step  = acc_step[ACC_BIT-1 -: ADDR_BIT] + act_poff;
    assign fword_zero = (act_fword == '0);
    assign burst      = (act_ncyc != '0);
    assign step_carry = carry & (state_q != IDLE);
    // Compare one bit wider so a freshly shrunk ncyc below the count still ends the burst.
    assign cnt_hit    = burst && (({1'b0, cnt_q} + (CYC_BIT+1)'(1)) >= {1'b0, act_ncyc});

    dds_cfg_stage #(
        .ACC_BIT  (ACC_BIT),
        .ADDR_BIT (ADDR_BIT),
        .CYC_BIT  (CYC_BIT)
    ) u_cfg (
        .sclk         (sclk),
        .rst          (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_fword_i  (cfg_fword),
        .cfg_poff_i   (cfg_poff),
        .cfg_ncyc_i   (cfg_ncyc),
        .cfg_sync_i   (cfg_sync),
        .state_i      (state_q),
        .wrap_i       (step_carry),
        .fword_zero_i (fword_zero),
        .fword_o      (act_fword),
        .poff_o       (act_poff),
        .ncyc_o       (act_ncyc)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        en_d      = en_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        terminate = 1'b0;
        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    addr_d  = act_poff;
                    en_d    = 1'b1;
                end
            end
            RUN, STOPPING: begin
                if (state_q == STOPPING) begin
                    terminate = carry | fword_zero;
                end else begin
                    terminate = (carry & (stop | cnt_hit)) | (fword_zero & (stop | burst));
                end
                acc_d  = acc_step;
                wrap_d = carry;
                if (carry) begin
                    cnt_d = cnt_q + CYC_BIT'(1);
                end
                if (terminate) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_step;
                    en_d   = 1'b1;
                    if (state_q == RUN && stop) begin
                        state_d = STOPPING;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign addr = addr_q;
    assign en   = en_q;
    assign wrap = wrap_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Scoreboard bench for dds_phase_acc at ACC_BIT=16, ADDR_BIT=12; expected outputs are
// queued per cycle from closed-form sequences and compared one time unit after each edge.
module tb_dds_phase_acc;

    logic        sclk = 1'b0;
    logic        rst, start, stop, cfg_valid, cfg_sync;
    logic        cfg_ready;
    logic [15:0] cfg_fword;
    logic [11:0] cfg_poff;
    logic [15:0] cfg_ncyc;
    logic [11:0] addr;
    logic        en, wrap, busy, done;

    int checks = 0;
    int errors = 0;

    // Packed view: {addr[11:0], en, wrap, busy, done, cfg_ready}
    logic [16:0] q_val[$];
    logic [16:0] q_msk[$];
    localparam logic [16:0] M_ALL    = 17'h1FFFF;
    localparam logic [16:0] M_NOWRAP = 17'h1FFF7;

    dds_phase_acc #(
        .ACC_BIT  (16),
        .ADDR_BIT (12),
        .CYC_BIT  (16)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_fword (cfg_fword),
        .cfg_poff  (cfg_poff),
        .cfg_ncyc  (cfg_ncyc),
        .cfg_sync  (cfg_sync),
        .addr      (addr),
        .en        (en),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 sclk = ~sclk;

    function automatic logic [16:0] pk(input logic [11:0] a, input logic e, input logic w,
                                       input logic b, input logic d, input logic r);
        return {a, e, w, b, d, r};
    endfunction

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input logic [16:0] v, input logic [16:0] m);
        q_val.push_back(v);
        q_msk.push_back(m);
    endtask

    task automatic drive_cfg(input logic [15:0] fw, input logic [11:0] po,
                             input logic [15:0] nc, input logic sy);
        cfg_fword = fw;
        cfg_poff  = po;
        cfg_ncyc  = nc;
        cfg_sync  = sy;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [16:0] act, ev, em;
        rst = 1'b1;
        push(pk(12'h000, 0, 0, 0, 0, 1), M_ALL);
        tick();
        act = pk(addr, en, wrap, busy, done, cfg_ready);
        ev = q_val.pop_front();
        em = q_msk.pop_front();
        checks++;
        if (((act ^ ev) & em) !== 17'd0) begin
            errors++;
            $display("FAIL reset got=%h want=%h", act, ev);
        end
        rst = 1'b0;
    endtask

    // Continuous ramp, then stop raised exactly on the carry step.
    task automatic test_continuous;
        logic [16:0] act, ev, em;
        drive_cfg(16'h1000, 12'h000, 16'd0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            start = (k == 0);
            stop  = (k == 48);
            if (k < 48)       push(pk(12'(k * 256), 1, (k > 0 && k % 16 == 0), 1, 0, 1), M_ALL);
            else if (k == 48) push(pk(12'hF00, 0, 0, 0, 1, 1), M_NOWRAP);
            else              push(pk(12'hF00, 0, 0, 0, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL continuous k=%0d got=%h want=%h", k, act, ev);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_burst;
        logic [16:0] act, ev, em;
        drive_cfg(16'h1000, 12'h000, 16'd2, 1'b0);
        for (int k = 0; k < 35; k++) begin
            start = (k == 0);
            if (k < 32)       push(pk(12'(k * 256), 1, (k == 16), 1, 0, 1), M_ALL);
            else if (k == 32) push(pk(12'hF00, 0, 0, 0, 1, 1), M_NOWRAP);
            else              push(pk(12'hF00, 0, 0, 0, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL burst k=%0d got=%h want=%h", k, act, ev);
            end
        end
        start = 1'b0;
    endtask

    // Immediate poff change mid-run, then stop early so STOPPING waits for the carry.
    task automatic test_imm_retune;
        logic [16:0] act, ev, em;
        int po;
        drive_cfg(16'h1000, 12'h000, 16'd0, 1'b0);
        cfg_fword = 16'h1000;
        cfg_poff  = 12'h800;
        cfg_ncyc  = 16'd0;
        cfg_sync  = 1'b0;
        for (int k = 0; k < 34; k++) begin
            start     = (k == 0);
            cfg_valid = (k == 4);
            stop      = (k == 19);
            po = (k >= 5) ? 32'h800 : 0;
            if (k < 32)       push(pk(12'(k * 256 + po), 1, (k == 16), 1, 0, 1), M_ALL);
            else if (k == 32) push(pk(12'h700, 0, 0, 0, 1, 1), M_NOWRAP);
            else              push(pk(12'h700, 0, 0, 0, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL imm_retune k=%0d got=%h want=%h", k, act, ev);
            end
        end
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // start and stop together in IDLE: start wins, the held stop then ends the run at the wrap.
    task automatic test_start_stop;
        logic [16:0] act, ev, em;
        for (int k = 0; k < 18; k++) begin
            start = (k == 0);
            stop  = (k <= 1);
            if (k < 16)       push(pk(12'(k * 256 + 32'h800), 1, 0, 1, 0, 1), M_ALL);
            else if (k == 16) push(pk(12'h700, 0, 0, 0, 1, 1), M_NOWRAP);
            else              push(pk(12'h700, 0, 0, 0, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL start_stop k=%0d got=%h want=%h", k, act, ev);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Synced retune offered at addr 0x500; step stays 0x100 until the wrap. Leaves the DUT running.
    task automatic test_sync_retune;
        logic [16:0] act, ev, em;
        drive_cfg(16'h1000, 12'h000, 16'd0, 1'b1);
        cfg_fword = 16'h2000;
        cfg_poff  = 12'h000;
        cfg_ncyc  = 16'd0;
        cfg_sync  = 1'b1;
        for (int k = 0; k < 28; k++) begin
            start     = (k == 0);
            cfg_valid = (k == 6);
            if (k < 16)       push(pk(12'(k * 256), 1, 0, 1, 0, (k < 6)), M_ALL);
            else if (k == 16) push(pk(12'h000, 1, 1, 1, 0, 1), M_ALL);
            else              push(pk(12'((k - 16) * 32'h200), 1, (k == 24), 1, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL sync_retune k=%0d got=%h want=%h", k, act, ev);
            end
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Park a synced word, reset mid-run, then run with fword 0 and stop.
    task automatic test_midrun_reset;
        logic [16:0] act, ev, em;
        cfg_fword = 16'h0100;
        cfg_poff  = 12'h000;
        cfg_sync  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cfg_valid = (k == 0);
            rst       = (k == 1);
            start     = (k == 2);
            stop      = (k == 6);
            if (k == 0)      push(pk(12'h800, 1, 0, 1, 0, 0), M_ALL);
            else if (k == 1) push(pk(12'h000, 0, 0, 0, 0, 1), M_ALL);
            else if (k < 6)  push(pk(12'h000, 1, 0, 1, 0, 1), M_ALL);
            else if (k == 6) push(pk(12'h000, 0, 0, 0, 1, 1), M_ALL);
            else             push(pk(12'h000, 0, 0, 0, 0, 1), M_ALL);
            tick();
            act = pk(addr, en, wrap, busy, done, cfg_ready);
            ev = q_val.pop_front();
            em = q_msk.pop_front();
            checks++;
            if (((act ^ ev) & em) !== 17'd0) begin
                errors++;
                $display("FAIL midrun_reset k=%0d got=%h want=%h", k, act, ev);
            end
        end
        cfg_valid = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_sync  = 1'b0;
        cfg_fword = '0;
        cfg_poff  = '0;
        cfg_ncyc  = '0;
        test_reset();
        test_continuous();
        test_burst();
        test_imm_retune();
        test_start_stop();
        test_sync_retune();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
